// File: rtl/half_add_pkg.sv
// Shared constants and the 1-bit half-add function used by the half_add block.
package half_add_pkg;

    localparam int MAX_WIDTH   = 64;
    localparam int MAX_LATENCY = 4;

    typedef struct packed {
        logic cout;
        logic sum;
    } ha_result_t;

    function automatic ha_result_t half_add_bit(input logic a, input logic b);
        ha_result_t r;
        r.sum  = a ^ b;
        r.cout = a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_add_cell.sv
// One-bit combinational half adder; the per-lane leaf of half_add.
module half_add_cell
    import half_add_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    ha_result_t res;

    assign res  = half_add_bit(a, b);
    assign sum  = res.sum;
    assign cout = res.cout;

endmodule

// File: rtl/half_add.sv
// Lane-parallel registered half adder with a LATENCY-deep data/valid pipeline.
module half_add
    import half_add_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("half_add: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
    end
    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("half_add: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
    end

    logic [WIDTH-1:0] cell_sum;
    logic [WIDTH-1:0] cell_cout;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_add_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .sum  (cell_sum[i]),
            .cout (cell_cout[i])
        );
    end

    logic [WIDTH-1:0]   sum_pipe   [LATENCY];
    logic [WIDTH-1:0]   cout_pipe  [LATENCY];
    logic [WIDTH-1:0]   stage_sum  [LATENCY];
    logic [WIDTH-1:0]   stage_cout [LATENCY];
    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY-1:0] stage_vld;

    // The valid chain depends only on in_valid and rst_n, so unknown
    // operand bits can never disturb it.
    assign stage_vld = LATENCY'({vld_pipe, in_valid});

    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            stage_sum[i]  = '0;
            stage_cout[i] = '0;
        end
        stage_sum[0]  = cell_sum;
        stage_cout[0] = cell_cout;
        for (int i = 1; i < LATENCY; i++) begin
            stage_sum[i]  = sum_pipe[i-1];
            stage_cout[i] = cout_pipe[i-1];
        end
    end

    // Inner stages load every cycle; the output stage loads only on a valid
    // slot so sum/cout hold their last result while out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                sum_pipe[i]  <= '0;
                cout_pipe[i] <= '0;
            end
        end else begin
            vld_pipe <= stage_vld;
            for (int i = 0; i < LATENCY; i++) begin
                if (i < LATENCY - 1 || stage_vld[i]) begin
                    sum_pipe[i]  <= stage_sum[i];
                    cout_pipe[i] <= stage_cout[i];
                end
            end
        end
    end

    assign out_valid = vld_pipe[LATENCY-1];
    assign sum       = sum_pipe[LATENCY-1];
    assign cout      = cout_pipe[LATENCY-1];

endmodule

// File: tb/tb_half_add.sv
// Scoreboard bench for half_add: four configurations share one random stimulus stream.
module tb_half_add;

    typedef struct {
        int          due;
        int          epoch;
        logic [63:0] s;
        logic [63:0] c;
    } exp_t;

    localparam int NDUT  = 4;
    localparam int DEPTH = 4096;

    function automatic int w_of(input int k);
        case (k)
            0:       return 8;
            1:       return 1;
            2:       return 4;
            default: return 64;
        endcase
    endfunction

    function automatic int l_of(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    // Reference: each lane is a 2-bit arithmetic sum of two 1-bit operands.
    function automatic exp_t ref_add(input logic [63:0] x, input logic [63:0] y,
                                     input int w, input int due, input int epoch);
        exp_t       e;
        logic [1:0] t;
        e.due   = due;
        e.epoch = epoch;
        e.s     = '0;
        e.c     = '0;
        for (int i = 0; i < w; i++) begin
            t      = 2'(x[i]) + 2'(y[i]);
            e.s[i] = t[0];
            e.c[i] = t[1];
        end
        return e;
    endfunction

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] a        = '0;
    logic [63:0] b        = '0;
    logic        drain    = 1'b0;
    int          ecnt     = 0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s dut%0d edge %0d: got %h expected %h", nm, k, ecnt, act, exp);
        end
    endtask

    for (genvar k = 0; k < NDUT; k++) begin : g
        localparam int W = w_of(k);
        localparam int L = l_of(k);

        logic [W-1:0] s;
        logic [W-1:0] c;
        logic         ov;
        exp_t         mem [DEPTH];
        int           wp = 0;
        int           rp = 0;
        int           epoch = 0;
        int           seen = 0;
        logic [63:0]  last_s = '0;
        logic [63:0]  last_c = '0;

        half_add #(.WIDTH(W), .LATENCY(L)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .a         (a[W-1:0]),
            .b         (b[W-1:0]),
            .out_valid (ov),
            .sum       (s),
            .cout      (c)
        );

        // Producer: an accepted operand set is due L-1 edges after the sampling edge.
        always @(posedge clk) begin
            if (!rst_n) begin
                epoch = epoch + 1;
            end else if (in_valid) begin
                mem[wp % DEPTH] = ref_add(a, b, W, ecnt + L, epoch);
                wp = wp + 1;
            end
        end

        // Monitor: pops whenever the DUT presents a result.
        always @(negedge clk) begin
            exp_t e;
            if (ecnt > 0) begin
                if (seen != epoch) begin
                    seen   = epoch;
                    last_s = '0;
                    last_c = '0;
                end
                while (rp < wp && mem[rp % DEPTH].epoch != epoch) rp = rp + 1;
                if (ov) begin
                    if (rp >= wp) begin
                        chk("spurious_valid", k, 64'(ov), 64'd0);
                    end else begin
                        e  = mem[rp % DEPTH];
                        rp = rp + 1;
                        chk("latency", k, 64'(ecnt), 64'(e.due));
                        chk("sum", k, 64'(s), e.s);
                        chk("cout", k, 64'(c), e.c);
                        last_s = e.s;
                        last_c = e.c;
                    end
                end else begin
                    if (rp < wp && mem[rp % DEPTH].due <= ecnt) begin
                        chk("missing_valid", k, 64'(ov), 64'd1);
                        rp = rp + 1;
                    end
                    chk("hold_sum", k, 64'(s), last_s);
                    chk("hold_cout", k, 64'(c), last_c);
                end
                if (drain) chk("drain_empty", k, 64'(wp - rp), 64'd0);
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        #1;
        rst_n    = r;
        in_valid = v;
        a        = x;
        b        = y;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] ones;
        logic [7:0]  idx;
        ones = '1;

        // Reset held with all-ones operands presented as valid.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, ones, ones);
        // The four operand combinations on consecutive valid cycles.
        step(1'b1, 1'b1, 64'd0, 64'd0);
        step(1'b1, 1'b1, 64'd0, ones);
        step(1'b1, 1'b1, ones, 64'd0);
        step(1'b1, 1'b1, ones, ones);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'd0, 64'd0);
        // Single valid pulse with mixed lanes.
        step(1'b1, 1'b1, 64'h0123_4567_89AB_CDF0, 64'hFEDC_BA98_7654_32AA);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, rnd64(), rnd64());
        // Gap pattern 1,0,1.
        step(1'b1, 1'b1, rnd64(), rnd64());
        step(1'b1, 1'b0, rnd64(), rnd64());
        step(1'b1, 1'b1, rnd64(), rnd64());
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, rnd64(), rnd64());
        // Two accepted sets, then a reset edge while they are in flight.
        step(1'b1, 1'b1, ones, ones);
        step(1'b1, 1'b1, ones, ones);
        step(1'b0, 1'b1, ones, ones);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'd0, 64'd0);
        // Unknown operands on an idle slot.
        step(1'b1, 1'b0, 'x, 'x);
        step(1'b1, 1'b1, ones, ones);
        step(1'b1, 1'b0, 64'd0, 64'd0);
        // Exhaustive pairs over the low four lanes, back-to-back.
        for (int i = 0; i < 256; i++) begin
            idx = 8'(i);
            step(1'b1, 1'b1, {rnd64() >> 4, idx[7:4]}, {rnd64() >> 4, idx[3:0]});
        end
        // Random traffic with sparse valids and occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), rnd64(), rnd64());
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        #1;
        drain = 1'b1;
        @(negedge clk);
        #1;
        drain = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
